inst_fetch_ctrl: RTL and testbench

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

---
 rtl/inst_fetch_ctrl.sv | 120 ++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: issues one instruction-bus request at a time,
// captures the returned word and presents it to decode until accepted. A
// redirect (IF_Flush) kills any in-flight fetch; a response that is already
// committed on the bus is drained in DISCARD so it cannot be mistaken for
// the redirected fetch.
module inst_fetch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IF_PC,
    output logic        PC_Wr,
    input  logic        IF_Flush,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        ID_Ready,
    output logic        IF_Valid,
    output logic [31:0] IF_Instr,
    output logic [31:0] IF_InstPC
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        addr_acc;

    // State register; reset abandons any bus transaction outright
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; bus handshakes arriving in the wrong state are ignored
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (addr_acc) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (inst_data_ok) state_d = IF_Flush ? S_IDLE : S_HOLD;
                else if (IF_Flush) state_d = S_DISCARD;
            end
            S_HOLD: begin
                if (IF_Flush || ID_Ready) state_d = S_IDLE;
            end
            S_DISCARD: begin
                // the stale response is the only one outstanding; once it
                // lands the bus is free, whatever else happens this cycle
                if (inst_data_ok) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: request only from IDLE, never while redirecting or in reset
    always_comb begin
        inst_req  = (state_q == S_IDLE) && rst && !IF_Flush;
        inst_addr = IF_PC;
        addr_acc  = inst_req && inst_addr_ok;
        PC_Wr     = rst && (addr_acc || IF_Flush);
    end

    // Datapath next values: capture request PC, load response, retire to decode
    always_comb begin
        pc_d      = pc_q;
        valid_d   = valid_q;
        instr_d   = instr_q;
        inst_pc_d = inst_pc_q;
        unique case (state_q)
            S_IDLE: begin
                if (addr_acc) pc_d = IF_PC;
            end
            S_WAIT: begin
                if (inst_data_ok && !IF_Flush) begin
                    valid_d   = 1'b1;
                    instr_d   = inst_rdata;
                    inst_pc_d = pc_q;
                end
            end
            S_HOLD: begin
                if (IF_Flush || ID_Ready) valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath registers; cleared by reset so decode never sees stale words
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= 32'h0000_0000;
            valid_q   <= 1'b0;
            instr_q   <= 32'h0000_0000;
            inst_pc_q <= 32'h0000_0000;
        end else begin
            pc_q      <= pc_d;
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    assign IF_Valid  = valid_q;
    assign IF_Instr  = instr_q;
    assign IF_InstPC = inst_pc_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a tiny upstream PC register model.
module tb_inst_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] IF_PC;
    logic        PC_Wr;
    logic        IF_Flush;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        ID_Ready;
    logic        IF_Valid;
    logic [31:0] IF_Instr;
    logic [31:0] IF_InstPC;
    logic [31:0] flush_tgt;

    int n_total = 0;
    int n_bad   = 0;

    inst_fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .IF_PC        (IF_PC),
        .PC_Wr        (PC_Wr),
        .IF_Flush     (IF_Flush),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .ID_Ready     (ID_Ready),
        .IF_Valid     (IF_Valid),
        .IF_Instr     (IF_Instr),
        .IF_InstPC    (IF_InstPC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream PC register: reset vector, +4 on accept, redirect target on flush
    always @(posedge clk or negedge rst) begin
        if (!rst)       IF_PC <= 32'hBFC0_0000;
        else if (PC_Wr) IF_PC <= IF_Flush ? flush_tgt : IF_PC + 32'd4;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b0;
        IF_Flush     = 1'b1;
        inst_addr_ok = 1'b1;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
        ID_Ready     = 1'b0;
        flush_tgt    = 32'h0;
        #1;
        // reset state, with flush/addr_ok high to prove gating
        check_val("rst_valid", {31'b0, IF_Valid}, 32'd0);
        check_val("rst_instr", IF_Instr, 32'h0);
        check_val("rst_instpc", IF_InstPC, 32'h0);
        check_val("rst_req", {31'b0, inst_req}, 32'd0);
        check_val("rst_pcwr", {31'b0, PC_Wr}, 32'd0);
        IF_Flush     = 1'b0;
        inst_addr_ok = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        check_val("first_req", {31'b0, inst_req}, 32'd1);
        check_val("first_addr", inst_addr, 32'hBFC0_0000);

        // basic fetch
        inst_addr_ok = 1'b1;
        ID_Ready     = 1'b1;
        #1;
        check_val("b_pcwr_acc", {31'b0, PC_Wr}, 32'd1);
        cyc();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h2402_0001;
        #1;
        check_val("b_req_wait", {31'b0, inst_req}, 32'd0);
        check_val("b_pcwr_wait", {31'b0, PC_Wr}, 32'd0);
        check_val("b_valid_wait", {31'b0, IF_Valid}, 32'd0);
        cyc();
        inst_data_ok = 1'b0;
        check_val("b_valid", {31'b0, IF_Valid}, 32'd1);
        check_val("b_instr", IF_Instr, 32'h2402_0001);
        check_val("b_instpc", IF_InstPC, 32'hBFC0_0000);
        check_val("b_pcwr_hold", {31'b0, PC_Wr}, 32'd0);
        cyc();
        check_val("b_valid_off", {31'b0, IF_Valid}, 32'd0);
        check_val("b_next_addr", inst_addr, 32'hBFC0_0004);
        check_val("b_next_req", {31'b0, inst_req}, 32'd1);

        // back-pressure, with stray handshakes in HOLD
        ID_Ready     = 1'b0;
        inst_addr_ok = 1'b1;
        cyc();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h1111_2222;
        cyc();
        for (int i = 0; i < 5; i++) begin
            inst_data_ok = (i == 1 || i == 2);
            inst_addr_ok = (i == 3);
            inst_rdata   = 32'hFFFF_FFFF;
            #1;
            check_val("bp_valid", {31'b0, IF_Valid}, 32'd1);
            check_val("bp_instr", IF_Instr, 32'h1111_2222);
            check_val("bp_instpc", IF_InstPC, 32'hBFC0_0004);
            check_val("bp_req", {31'b0, inst_req}, 32'd0);
            check_val("bp_pcwr", {31'b0, PC_Wr}, 32'd0);
            cyc();
        end
        inst_data_ok = 1'b0;
        inst_addr_ok = 1'b0;
        ID_Ready     = 1'b1;
        #1;
        check_val("bp_valid_last", {31'b0, IF_Valid}, 32'd1);
        cyc();
        check_val("bp_done", {31'b0, IF_Valid}, 32'd0);
        check_val("bp_next_addr", inst_addr, 32'hBFC0_0008);

        // flush in WAIT, response 3 cycles later
        ID_Ready     = 1'b0;
        inst_addr_ok = 1'b1;
        cyc();
        inst_addr_ok = 1'b0;
        IF_Flush     = 1'b1;
        flush_tgt    = 32'h8000_1000;
        #1;
        check_val("fw_pcwr", {31'b0, PC_Wr}, 32'd1);
        check_val("fw_req", {31'b0, inst_req}, 32'd0);
        cyc();
        IF_Flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check_val("fw_disc_req", {31'b0, inst_req}, 32'd0);
            check_val("fw_disc_valid", {31'b0, IF_Valid}, 32'd0);
            cyc();
        end
        inst_data_ok = 1'b1;
        inst_rdata   = 32'hDEAD_BEEF;
        #1;
        check_val("fw_drop_req", {31'b0, inst_req}, 32'd0);
        cyc();
        inst_data_ok = 1'b0;
        #1;
        check_val("fw_valid", {31'b0, IF_Valid}, 32'd0);
        check_val("fw_req_back", {31'b0, inst_req}, 32'd1);
        check_val("fw_new_addr", inst_addr, 32'h8000_1000);

        // flush coincident with data_ok
        inst_addr_ok = 1'b1;
        cyc();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'hCAFE_F00D;
        IF_Flush     = 1'b1;
        flush_tgt    = 32'h8000_2000;
        #1;
        check_val("fc_pcwr", {31'b0, PC_Wr}, 32'd1);
        cyc();
        inst_data_ok = 1'b0;
        IF_Flush     = 1'b0;
        #1;
        check_val("fc_valid", {31'b0, IF_Valid}, 32'd0);
        check_val("fc_req", {31'b0, inst_req}, 32'd1);
        check_val("fc_addr", inst_addr, 32'h8000_2000);

        // addr_ok stall
        for (int i = 0; i < 4; i++) begin
            #1;
            check_val("st_req", {31'b0, inst_req}, 32'd1);
            check_val("st_addr", inst_addr, 32'h8000_2000);
            check_val("st_pcwr", {31'b0, PC_Wr}, 32'd0);
            cyc();
        end
        inst_addr_ok = 1'b1;
        #1;
        check_val("st_pcwr_acc", {31'b0, PC_Wr}, 32'd1);
        cyc();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h8C22_0004;
        cyc();
        inst_data_ok = 1'b0;
        check_val("st_valid", {31'b0, IF_Valid}, 32'd1);
        check_val("st_instr", IF_Instr, 32'h8C22_0004);
        check_val("st_instpc", IF_InstPC, 32'h8000_2000);

        // reset while holding an instruction
        #2;
        rst = 1'b0;
        #1;
        check_val("rh_valid", {31'b0, IF_Valid}, 32'd0);
        check_val("rh_instr", IF_Instr, 32'h0);
        check_val("rh_instpc", IF_InstPC, 32'h0);
        check_val("rh_req", {31'b0, inst_req}, 32'd0);
        cyc();
        rst = 1'b1;
        #1;
        check_val("rh_req_back", {31'b0, inst_req}, 32'd1);
        check_val("rh_addr", inst_addr, 32'hBFC0_0000);
        inst_addr_ok = 1'b1;
        cyc();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h2402_0001;
        cyc();
        inst_data_ok = 1'b0;
        check_val("rh_valid2", {31'b0, IF_Valid}, 32'd1);
        check_val("rh_instpc2", IF_InstPC, 32'hBFC0_0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
